// File: rtl/arbitro_memoria_dados.sv
// Arbiter sharing one single-port synchronous data memory between the CPU and a debug/loader port.
// Tie-break is round-robin by default; define ARB_PRIO_FIXA_EN to always grant ties to the debug port.
module arbitro_memoria_dados #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int READ_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // CPU port
  input  logic          c_req_i,
  input  logic          c_we_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [DW-1:0] c_wdata_i,
  output logic          c_ack_o,
  output logic [DW-1:0] c_rdata_o,
  // debug / loader port
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  // memory side
  output logic          m_cen_o,
  output logic          m_wen_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic [DW-1:0] m_rdata_i,
  // status
  output logic          ocupado_o,
  output logic          ultimo_o
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EMITE    = 2'd1,
    ESPERA   = 2'd2,
    RESPOSTA = 2'd3
  } estado_e;

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT);

  estado_e       estado_q;
  logic [1:0]    cnt_q;
  logic          m_cen_q;
  logic          m_wen_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic          c_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] c_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          ocupado_q;
  logic          ultimo_q;

  logic          grant_dbg_d;
  logic          wen_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // Winner selection and payload mux for the grant taken in OCIOSO.
  // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    grant_dbg_d = 1'b0;
`ifdef ARB_PRIO_FIXA_EN
    grant_dbg_d = d_req_i;
`else
    // With both requesting, the port that did not win last time gets the grant.
    grant_dbg_d = d_req_i & (~c_req_i | ~ultimo_q);
`endif
    wen_d   = grant_dbg_d ? d_we_i    : c_we_i;
    addr_d  = grant_dbg_d ? d_addr_i  : c_addr_i;
    wdata_d = grant_dbg_d ? d_wdata_i : c_wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      estado_q  <= OCIOSO;
      cnt_q     <= 2'd0;
      m_cen_q   <= 1'b0;
      m_wen_q   <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      ocupado_q <= 1'b0;
      ultimo_q  <= 1'b1;
    end else begin
      m_cen_q <= 1'b0;
      c_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (estado_q)
        OCIOSO: begin
          if (c_req_i || d_req_i) begin
            estado_q  <= EMITE;
            ocupado_q <= 1'b1;
            ultimo_q  <= grant_dbg_d;
            m_cen_q   <= 1'b1;
            m_wen_q   <= wen_d;
            m_addr_q  <= addr_d;
            m_wdata_q <= wdata_d;
          end
        end
        EMITE: begin
          if (m_wen_q) begin
            estado_q <= RESPOSTA;
            c_ack_q  <= ~ultimo_q;
            d_ack_q  <= ultimo_q;
          end else begin
            estado_q <= ESPERA;
            cnt_q    <= LAT_INIT;
          end
        end
        ESPERA: begin
          cnt_q <= cnt_q - 2'd1;
          // The edge that takes the counter to zero is the one where read data is valid.
          if (cnt_q == 2'd1) begin
            estado_q <= RESPOSTA;
            if (ultimo_q) begin
              d_rdata_q <= m_rdata_i;
              d_ack_q   <= 1'b1;
            end else begin
              c_rdata_q <= m_rdata_i;
              c_ack_q   <= 1'b1;
            end
          end
        end
        RESPOSTA: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
        end
        default: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign c_ack_o   = c_ack_q;
  assign d_ack_o   = d_ack_q;
  assign c_rdata_o = c_rdata_q;
  assign d_rdata_o = d_rdata_q;
  assign m_cen_o   = m_cen_q;
  assign m_wen_o   = m_wen_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign ocupado_o = ocupado_q;
  assign ultimo_o  = ultimo_q;

endmodule

// File: doc/arbitro_memoria_dados.md
# arbitro_memoria_dados

Two-port arbiter sharing the single-port synchronous data memory (MD) between the processor datapath (CPU port, driven by the control FSM's load/store sequencing) and a debug/loader port used to preload and inspect memory. It serialises accesses, drives the memory control strobes, and returns one-cycle acknowledge pulses with registered read data. Tie-breaking is round-robin by default.

## Interface
- AW, 8, address width in bits
- DW, 16, data width in bits
- READ_LAT, 1, memory read latency in cycles, legal range 1..3
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  CPU request, level, sampled only in OCIOSO
- c_we  in  1  CPU write enable (1 = store, 0 = load)
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_ack  out  1  CPU one-cycle completion pulse
- c_rdata  out  DW  CPU read data, valid in c_ack cycle, held afterwards
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug port, same meaning as CPU port
- d_ack  out  1  debug completion pulse
- d_rdata  out  DW  debug read data, same rules as c_rdata
- m_cen  out  1  memory chip enable, one-cycle pulse per access
- m_wen  out  1  memory write enable, qualified by m_cen
- m_addr  out  AW  memory address, registered
- m_wdata  out  DW  memory write data, registered
- m_rdata  in  DW  memory read data
- ocupado  out  1  high in every state except OCIOSO
- ultimo  out  1  port of last grant (0 = CPU, 1 = debug)

## Operation
- States: OCIOSO, EMITE, ESPERA, RESPOSTA.
- OCIOSO: if any req, pick winner, register we/addr/wdata into m_wen/m_addr/m_wdata, update ultimo, go EMITE; else stay.
- Winner: single requester always wins; both requesting -> port != ultimo (round-robin).
- EMITE: m_cen = 1 for exactly this cycle. Write -> RESPOSTA. Read -> ESPERA, load wait counter with READ_LAT.
- ESPERA: decrement counter each cycle; at the edge where it reaches zero, capture m_rdata into the granted port's rdata register, go RESPOSTA.
- RESPOSTA: assert ack of granted port only; requests not sampled; go OCIOSO.
- Payload is registered at grant; later changes to addr/wdata/we are ignored until the next grant. Requester must drop req at or before the edge ending its ack cycle, otherwise a new access of the same kind is issued.
- rdata of a port changes only on a read completion for that port; writes and other-port reads leave it untouched.
- Reset (async, any state): state OCIOSO, m_cen 0, m_wen 0, m_addr 0, m_wdata 0, c_ack/d_ack 0, c_rdata/d_rdata 0, ocupado 0, ultimo 1 (CPU wins first tie), counter 0. In-flight access abandoned with no ack; a write already strobed stays in memory.

## Timing
- req sampled high at edge ending cycle T (OCIOSO): EMITE at T+1.
- Write: ack at T+2. Read: ack at T+2+READ_LAT (READ_LAT=1 -> T+3).
- m_rdata sampled in cycle T+1+READ_LAT.
- Back-to-back same port with req held: write every 3 cycles, read every 3+READ_LAT cycles.
- Both ports requesting continuously: grants strictly alternate.
- ack never asserted for both ports in one cycle; at most one m_cen per access.

## Configuration
- ARB_PRIO_FIXA_EN defined: ties always granted to debug port (loader can halt CPU memory traffic); ultimo still updated for observation.
- Undefined: round-robin tie-break as above.

## Test plan
- Reset release, CPU write addr 0x12 data 0xBEEF -> m_cen/m_wen high at T+1 with m_addr 0x12, c_ack at T+2, d_ack never high.
- CPU read 0x12 with READ_LAT=1 -> c_ack at T+3, c_rdata = 0xBEEF, d_rdata stays 0x0000.
- Both ports read simultaneously, req held: first grant CPU (ultimo reset 1), then debug, alternating; with ARB_PRIO_FIXA_EN debug wins every tie.
- READ_LAT=3, debug read -> d_ack at T+5; addr changed during ESPERA has no effect.
- reset asserted in ESPERA -> all outputs at reset values immediately, no ack; next request restarts from OCIOSO with T+3 latency.
- CPU holds req through c_ack -> second access issued, m_cen at T+4 (write case).
